// File: rtl/frequency_analyzer_controller.sv
// Sequences a frequency analyzer through clear/count/settle/capture/report windows,
// classifies each window's f0/f1 counts and hands the result over valid/ready.
module frequency_analyzer_controller #(
    parameter int WINDOW_CYCLES = 500000,
    parameter int CLEAR_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int MIN_COUNT     = 50
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        continuous,
    input  logic        abort,
    output logic        analyzer_enable,
    output logic        analyzer_clear,
    input  logic [31:0] f0_value,
    input  logic [31:0] f1_value,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [1:0]  result_code,
    output logic [31:0] result_f0,
    output logic [31:0] result_f1,
    output logic        busy
);

    localparam int MAX_A      = (WINDOW_CYCLES > CLEAR_CYCLES) ? WINDOW_CYCLES : CLEAR_CYCLES;
    localparam int MAX_CYCLES = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MEASURE,
        S_SETTLE,
        S_CAPTURE,
        S_REPORT
    } state_t;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_F0   = 2'b01;
    localparam logic [1:0] CODE_F1   = 2'b10;
    localparam logic [1:0] CODE_TIE  = 2'b11;

    state_t        state, next_state;
    logic [CW-1:0] cycle_count, reload_value;

    function automatic logic [1:0] classify(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] min_count;
        min_count = 32'(MIN_COUNT);
        if (a == b)     return (a >= min_count) ? CODE_TIE : CODE_NONE;
        else if (a > b) return (a >= min_count) ? CODE_F0  : CODE_NONE;
        else            return (b >= min_count) ? CODE_F1  : CODE_NONE;
    endfunction

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:    if (start) next_state = S_CLEAR;
            S_CLEAR:   if (cycle_count == '0) next_state = S_MEASURE;
            S_MEASURE: if (cycle_count == '0) next_state = S_SETTLE;
            S_SETTLE:  if (cycle_count == '0) next_state = S_CAPTURE;
            S_CAPTURE: next_state = S_REPORT;
            S_REPORT:  if (result_ready) next_state = continuous ? S_CLEAR : S_IDLE;
            default:   next_state = S_IDLE;
        endcase
        if (abort) next_state = S_IDLE;
    end

    // Counter is loaded with (length-1) on entry and counts down to zero in place.
    always_comb begin
        reload_value = '0;
        unique case (next_state)
            S_CLEAR:   reload_value = CW'(CLEAR_CYCLES - 1);
            S_MEASURE: reload_value = CW'(WINDOW_CYCLES - 1);
            S_SETTLE:  reload_value = CW'(SETTLE_CYCLES - 1);
            default:   reload_value = '0;
        endcase
    end

    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cycle_count <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                cycle_count <= reload_value;
            else if (cycle_count != '0)
                cycle_count <= cycle_count - CW'(1);
        end
    end

    // Outputs are registered from next_state so they line up exactly with the state they describe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            analyzer_enable <= 1'b0;
            analyzer_clear  <= 1'b0;
            result_valid    <= 1'b0;
            busy            <= 1'b0;
            result_code     <= CODE_NONE;
            result_f0       <= '0;
            result_f1       <= '0;
        end else begin
            analyzer_clear  <= (next_state == S_CLEAR);
            analyzer_enable <= (next_state == S_MEASURE);
            result_valid    <= (next_state == S_REPORT);
            busy            <= (next_state != S_IDLE);
            if (state == S_CAPTURE && next_state == S_REPORT) begin
                result_f0   <= f0_value;
                result_f1   <= f1_value;
                result_code <= classify(f0_value, f1_value);
            end
        end
    end

endmodule

// File: tb/tb_frequency_analyzer_controller.sv
// Scoreboard bench: stimulus pushes expected window results, a negedge monitor pops and
// compares them and checks window timing, result stability and clear/enable exclusivity.
module tb_frequency_analyzer_controller;

    localparam int WINDOW = 1000;
    localparam int CLR    = 2;
    localparam int SET    = 2;
    localparam int MIN    = 50;
    localparam int PERIOD = CLR + WINDOW + SET + 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        abort = 1'b0;
    logic        result_ready = 1'b1;
    logic [31:0] f0_value = '0;
    logic [31:0] f1_value = '0;
    logic        analyzer_enable, analyzer_clear, result_valid, busy;
    logic [1:0]  result_code;
    logic [31:0] result_f0, result_f1;

    frequency_analyzer_controller #(
        .WINDOW_CYCLES(WINDOW), .CLEAR_CYCLES(CLR), .SETTLE_CYCLES(SET), .MIN_COUNT(MIN)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .continuous(continuous),
        .abort(abort), .analyzer_enable(analyzer_enable), .analyzer_clear(analyzer_clear),
        .f0_value(f0_value), .f1_value(f1_value), .result_valid(result_valid),
        .result_ready(result_ready), .result_code(result_code), .result_f0(result_f0),
        .result_f1(result_f1), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  code;
        logic [31:0] f0;
        logic [31:0] f1;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference classification straight from the rules: absent/absent, larger wins, equal ties.
    function automatic logic [1:0] model_code(input int unsigned a, input int unsigned b);
        if (a < MIN && b < MIN) return 2'b00;
        if (a > b)              return 2'b01;
        if (b > a)              return 2'b10;
        return 2'b11;
    endfunction

    // Monitor
    initial begin
        logic        prev_valid;
        int          clr_cnt, en_cnt, gap;
        logic [1:0]  held_code;
        logic [31:0] held_f0, held_f1;
        exp_t        e;
        prev_valid = 1'b0;
        clr_cnt = 0; en_cnt = 0; gap = 0;
        held_code = '0; held_f0 = '0; held_f1 = '0;
        forever begin
            @(negedge clock);
            check("clear_enable_exclusive", 32'(analyzer_clear & analyzer_enable), 0);
            if (!reset_n || !busy) begin
                clr_cnt = 0; en_cnt = 0; gap = 0;
            end else begin
                if (analyzer_clear) clr_cnt++;
                if (analyzer_enable) en_cnt++;
                if (en_cnt > 0 && !analyzer_enable && !result_valid) gap++;
            end
            if (result_valid && !prev_valid) begin
                check("clear_cycles", clr_cnt, CLR);
                check("enable_cycles", en_cnt, WINDOW);
                check("settle_capture_gap", gap, SET + 1);
                if (sb_q.size() == 0) begin
                    check("scoreboard_has_entry", 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    check("result_code", 32'(result_code), 32'(e.code));
                    check("result_f0", result_f0, e.f0);
                    check("result_f1", result_f1, e.f1);
                end
                held_code = result_code; held_f0 = result_f0; held_f1 = result_f1;
                clr_cnt = 0; en_cnt = 0; gap = 0;
            end else if (result_valid && prev_valid) begin
                check("hold_code", 32'(result_code), 32'(held_code));
                check("hold_f0", result_f0, held_f0);
                check("hold_f1", result_f1, held_f1);
                check("report_quiet", 32'(analyzer_clear | analyzer_enable), 0);
            end
            prev_valid = result_valid;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_window(input int unsigned a, input int unsigned b);
        f0_value = a;
        f1_value = b;
        sb_q.push_back('{model_code(a, b), a, b});
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int at_cycle);
        int n;
        n = 0;
        while (!result_valid && n < 3 * PERIOD) begin
            tick();
            n++;
        end
        check("valid_within_budget", 32'(result_valid), 1);
        at_cycle = cycle;
    endtask

    task automatic wait_enable();
        int n;
        n = 0;
        while (!analyzer_enable && n < 20) begin
            tick();
            n++;
        end
        check("enable_within_budget", 32'(analyzer_enable), 1);
    endtask

    task automatic run_window(input int unsigned a, input int unsigned b);
        int c;
        start_window(a, b);
        wait_valid(c);
        tick();
        check("valid_dropped", 32'(result_valid), 0);
        check("idle_after_handshake", 32'(busy), 0);
    endtask

    initial begin
        int c1, c2, c3;
        int unsigned a, b;

        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_valid", 32'(result_valid), 0);
        check("reset_enable", 32'(analyzer_enable), 0);
        check("reset_clear", 32'(analyzer_clear), 0);
        check("reset_code", 32'(result_code), 0);
        check("reset_f0", result_f0, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Basic window, with an ignored start mid-measurement
        start_window(120, 30);
        wait_enable();
        repeat (300) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(c1);
        tick();
        check("idle_after_first", 32'(busy), 0);

        // Classification cases, thresholds and randomized counts
        run_window(40, 45);
        run_window(80, 80);
        run_window(10, 200);
        run_window(50, 49);
        run_window(49, 49);
        run_window(50, 50);
        for (int i = 0; i < 6; i++) begin
            a = $urandom_range(0, 120);
            b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 120);
            run_window(a, b);
        end

        // Asynchronous reset mid-MEASURE
        start_window(200, 5);
        wait_enable();
        repeat (100) tick();
        reset_n = 1'b0;
        #1;
        check("async_reset_enable", 32'(analyzer_enable), 0);
        check("async_reset_valid", 32'(result_valid), 0);
        check("async_reset_busy", 32'(busy), 0);
        check("async_reset_code", 32'(result_code), 0);
        void'(sb_q.pop_back());
        tick();
        reset_n = 1'b1;
        tick();

        // Backpressure: result held for 500 cycles
        result_ready = 1'b0;
        start_window(33, 90);
        wait_valid(c1);
        repeat (500) tick();
        check("stall_valid_held", 32'(result_valid), 1);
        check("stall_busy", 32'(busy), 1);
        result_ready = 1'b1;
        tick();
        check("stall_release_valid", 32'(result_valid), 0);
        repeat (3) tick();
        check("stall_no_rearm", 32'(busy), 0);

        // Continuous mode: back-to-back windows
        continuous = 1'b1;
        start_window(300, 299);
        sb_q.push_back('{model_code(300, 299), 300, 299});
        sb_q.push_back('{model_code(300, 299), 300, 299});
        wait_valid(c1);
        tick();
        wait_valid(c2);
        check("continuous_period_1", c2 - c1, PERIOD);
        tick();
        wait_valid(c3);
        check("continuous_period_2", c3 - c2, PERIOD);
        continuous = 1'b0;
        tick();
        check("continuous_stop", 32'(busy), 0);

        // Abort at MEASURE cycle 400
        start_window(90, 10);
        wait_enable();
        repeat (399) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        void'(sb_q.pop_back());
        check("abort_busy", 32'(busy), 0);
        check("abort_enable", 32'(analyzer_enable), 0);
        check("abort_valid", 32'(result_valid), 0);
        check("abort_keeps_code", 32'(result_code), 32'(model_code(300, 299)));
        check("abort_keeps_f0", result_f0, 300);

        // start together with abort is ignored
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_with_abort_ignored", 32'(busy), 0);

        // Abort coincident with handshake, continuous set
        result_ready = 1'b0;
        start_window(77, 77);
        wait_valid(c1);
        tick();
        result_ready = 1'b1;
        continuous = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        continuous = 1'b0;
        check("abort_hs_busy", 32'(busy), 0);
        check("abort_hs_valid", 32'(result_valid), 0);
        check("abort_hs_enable", 32'(analyzer_enable), 0);
        check("abort_hs_clear", 32'(analyzer_clear), 0);
        check("abort_hs_keeps_code", 32'(result_code), 3);
        check("abort_hs_keeps_f1", result_f1, 77);

        // Clean window after abort
        run_window(500, 600);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
